// File: rtl/resonator_pkg.sv
// Shared types, widths and helpers for the resonator MAC sequencer.
// Coefficients are Q2.14; the accumulator holds full-precision sums of three 33-bit products.
package resonator_pkg;

   typedef enum logic [2:0] {IDLE, LOAD, MAC0, MAC1, MAC2, OUT} state_t;
   typedef enum logic [1:0] {MAC_HOLD, MAC_LOAD, MAC_ADD, MAC_SUB} mac_op_t;
   typedef logic signed [15:0] coef_t;

   localparam int COEF_FRAC = 14;
   localparam int ACC_W     = 36;

   localparam logic [1:0] ADDR_B0 = 2'd0;
   localparam logic [1:0] ADDR_A1 = 2'd1;
   localparam logic [1:0] ADDR_A2 = 2'd2;

   localparam logic signed [ACC_W-1:0] SAT_HI = 32767;
   localparam logic signed [ACC_W-1:0] SAT_LO = -32768;

   function automatic coef_t sat16(input logic signed [ACC_W-1:0] v);
      if (v > SAT_HI)
         return 16'sh7FFF;
      else if (v < SAT_LO)
         return 16'sh8000;
      else
         return v[15:0];
   endfunction

endpackage

// File: rtl/resonator_mac_sequencer_if.sv
// Sample, coefficient-config and result bundle of the resonator sequencer.
// slave is the sequencer side; master is the surrounding system.
interface resonator_mac_sequencer_if;
   import resonator_pkg::*;

   coef_t       d;
   logic        cfg_we;
   logic [1:0]  cfg_addr;
   coef_t       cfg_wdata;
   coef_t       q;
   logic        q_valid;
   logic        q_ready;
   logic        enable;
   logic        busy;
   logic        overrun;
   logic        clr_overrun;

   modport slave (
      input  d, cfg_we, cfg_addr, cfg_wdata, q_ready, clr_overrun,
      output q, q_valid, enable, busy, overrun
   );

   modport master (
      output d, cfg_we, cfg_addr, cfg_wdata, q_ready, clr_overrun,
      input  q, q_valid, enable, busy, overrun
   );

endinterface

// File: rtl/resonator_mac.sv
// Registered 16x17 multiply-accumulate (load/add/subtract/hold) with a saturating Q2.14 output.
// One product per cycle; the result is visible the cycle after the op, no backpressure.
module resonator_mac
   import resonator_pkg::*;
(
   input  logic               clk,
   input  logic               reset_n,
   input  mac_op_t            op,
   input  coef_t              coef,
   input  logic signed [16:0] operand,
   output coef_t              y
);

   logic signed [32:0]      prod;
   logic signed [ACC_W-1:0] prod_ext;
   logic signed [ACC_W-1:0] acc;

   assign prod     = 33'(coef) * 33'(operand);
   assign prod_ext = ACC_W'(prod);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         acc <= '0;
      else begin
         case (op)
            MAC_LOAD: acc <= prod_ext;
            MAC_ADD:  acc <= acc + prod_ext;
            MAC_SUB:  acc <= acc - prod_ext;
            default:  acc <= acc;
         endcase
      end
   end

   // arithmetic shift floors toward -inf before clamping
   assign y = sat16(acc >>> COEF_FRAC);

endmodule

// File: rtl/resonator_mac_sequencer.sv
// Resonator y=b0*(x0-x2)+a1*y1-a2*y2 over one shared multiplier; internal sample tick.
// enable in cycle T gives q_valid in T+5; an unaccepted result is overwritten and flags overrun.
module resonator_mac_sequencer
   import resonator_pkg::*;
#(
   parameter int unsigned CLOCK_TICKS = 100000,
   parameter coef_t       B0_RST      = 16'sh0010,
   parameter coef_t       A1_RST      = 16'sh74B8,
   parameter coef_t       A2_RST      = 16'sh3EBA
)(
   input logic                       clk,
   input logic                       reset_n,
   resonator_mac_sequencer_if.slave  bus
);

   localparam int CNT_W = (CLOCK_TICKS > 1) ? $clog2(CLOCK_TICKS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCK_TICKS - 1);

   logic [CNT_W-1:0]   tick_cnt;
   logic               tick;
   state_t             state, state_nxt;
   logic               busy, start, result_wr, ovr_set;
   mac_op_t            mac_op;
   coef_t              mul_coef;
   logic signed [16:0] mul_opnd;
   coef_t              mac_y;
   coef_t              b0, a1, a2, b0_s, a1_s, a2_s;
   coef_t              x0, x1, x2, y1, y2;
   logic signed [16:0] diff;
   coef_t              q_r;
   logic               q_valid_r, overrun_r;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         tick_cnt <= '0;
      else if (tick_cnt == CNT_LAST)
         tick_cnt <= '0;
      else
         tick_cnt <= tick_cnt + CNT_W'(1);
   end

   assign tick = (tick_cnt == CNT_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (tick) state_nxt = LOAD;
         LOAD:    state_nxt = MAC0;
         MAC0:    state_nxt = MAC1;
         MAC1:    state_nxt = MAC2;
         MAC2:    state_nxt = OUT;
         OUT:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // operand mux: the op issued in a state lands in acc on the edge leaving it
   always_comb begin
      busy     = (state != IDLE);
      mac_op   = MAC_HOLD;
      mul_coef = b0_s;
      mul_opnd = diff;
      case (state)
         LOAD: mac_op = MAC_LOAD;
         MAC0: begin
            mac_op   = MAC_ADD;
            mul_coef = a1_s;
            mul_opnd = {y1[15], y1};
         end
         MAC1: begin
            mac_op   = MAC_SUB;
            mul_coef = a2_s;
            mul_opnd = {y2[15], y2};
         end
         default: ;
      endcase
   end

   assign start     = (state == IDLE) && tick;
   assign result_wr = (state == MAC2);
   assign ovr_set   = (result_wr && q_valid_r && !bus.q_ready) || (tick && busy);

   resonator_mac u_mac (
      .clk     (clk),
      .reset_n (reset_n),
      .op      (mac_op),
      .coef    (mul_coef),
      .operand (mul_opnd),
      .y       (mac_y)
   );

   // live registers take writes any time; shadows isolate the sample in flight
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         b0   <= B0_RST;
         a1   <= A1_RST;
         a2   <= A2_RST;
         b0_s <= B0_RST;
         a1_s <= A1_RST;
         a2_s <= A2_RST;
      end else begin
         if (bus.cfg_we) begin
            case (bus.cfg_addr)
               ADDR_B0: b0 <= bus.cfg_wdata;
               ADDR_A1: a1 <= bus.cfg_wdata;
               ADDR_A2: a2 <= bus.cfg_wdata;
               default: ;
            endcase
         end
         if (start) begin
            b0_s <= b0;
            a1_s <= a1;
            a2_s <= a2;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         x0   <= '0;
         x1   <= '0;
         x2   <= '0;
         y1   <= '0;
         y2   <= '0;
         diff <= '0;
      end else begin
         if (start) begin
            x0   <= bus.d;
            diff <= {bus.d[15], bus.d} - {x2[15], x2};
         end
         if (result_wr) begin
            x2 <= x1;
            x1 <= x0;
            y2 <= y1;
            y1 <= mac_y;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q_r       <= '0;
         q_valid_r <= 1'b0;
         overrun_r <= 1'b0;
      end else begin
         if (result_wr) begin
            q_r       <= mac_y;
            q_valid_r <= 1'b1;
         end else if (q_valid_r && bus.q_ready) begin
            q_valid_r <= 1'b0;
         end
         if (ovr_set)
            overrun_r <= 1'b1;
         else if (bus.clr_overrun)
            overrun_r <= 1'b0;
      end
   end

   assign bus.q       = q_r;
   assign bus.q_valid = q_valid_r;
   assign bus.enable  = tick;
   assign bus.busy    = busy;
   assign bus.overrun = overrun_r;

endmodule

// File: tb/tb_resonator_mac_sequencer.sv
// Directed bench for resonator_mac_sequencer with a queue scoreboard fed by a reference model.
module tb_resonator_mac_sequencer;
   import resonator_pkg::*;

   localparam int unsigned TICKS = 16;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   resonator_mac_sequencer_if bus ();

   resonator_mac_sequencer #(
      .CLOCK_TICKS (TICKS),
      .B0_RST      (16'sh0010),
      .A1_RST      (16'sh74B8),
      .A2_RST      (16'sh3EBA)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int checks   = 0;
   int failures = 0;

   longint exp_q[$];
   longint mb0, ma1, ma2, mx1, mx2, my1, my2;
   logic [1:0] cfg_a;
   coef_t      cfg_v;
   longint     got;

   task automatic check(input string tag, input logic signed [63:0] obs,
                        input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_push(input longint dv);
      longint acc, y;
      acc = mb0 * (dv - mx2) + ma1 * my1 - ma2 * my2;
      y = acc >>> 14;
      if (y > 32767)  y = 32767;
      if (y < -32768) y = -32768;
      exp_q.push_back(y);
      mx2 = mx1;
      mx1 = dv;
      my2 = my1;
      my1 = y;
   endtask

   task automatic do_reset();
      reset_n          = 1'b0;
      bus.d            = '0;
      bus.cfg_we       = 1'b0;
      bus.cfg_addr     = '0;
      bus.cfg_wdata    = '0;
      bus.q_ready      = 1'b1;
      bus.clr_overrun  = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_q", bus.q, 0);
      check("rst_q_valid", bus.q_valid, 0);
      check("rst_enable", bus.enable, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_overrun", bus.overrun, 0);
      mb0 = 16; ma1 = 29880; ma2 = 16058;
      mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
      exp_q.delete();
      reset_n = 1'b1;
   endtask

   task automatic cfg_write(input logic [1:0] addr, input coef_t val);
      @(negedge clk);
      bus.cfg_we    = 1'b1;
      bus.cfg_addr  = addr;
      bus.cfg_wdata = val;
      @(negedge clk);
      bus.cfg_we    = 1'b0;
   endtask

   // act: 0 none, 1 cfg write (cfg_a/cfg_v), 2 clr_overrun pulse, 3 assert reset; applied k cycles after enable
   task automatic do_sample(input longint dv, input int act_k, input int act,
                            input bit chk_early, output longint res);
      int n;
      res = 0;
      n = 0;
      @(negedge clk);
      while (bus.enable !== 1'b1 && n < 3 * TICKS) begin
         @(negedge clk);
         n++;
      end
      check("tick_seen", bus.enable, 1);
      bus.d = 16'(dv);
      if (act != 3) model_push(dv);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         bus.cfg_we      = 1'b0;
         bus.clr_overrun = 1'b0;
         if (k == 1) begin
            check("busy_load", bus.busy, 1);
            check("enable_pulse", bus.enable, 0);
         end
         if (k == 4 && chk_early) check("q_valid_early", bus.q_valid, 0);
         if (k == 5) begin
            check("q_valid_lat", bus.q_valid, 1);
            if (exp_q.size() == 0) check("sb_empty", exp_q.size(), 1);
            else check("q", bus.q, exp_q.pop_front());
            res = longint'(bus.q);
         end
         if (k == act_k) begin
            if (act == 1) begin
               bus.cfg_we    = 1'b1;
               bus.cfg_addr  = cfg_a;
               bus.cfg_wdata = cfg_v;
            end else if (act == 2) begin
               bus.clr_overrun = 1'b1;
            end else if (act == 3) begin
               reset_n = 1'b0;
               return;
            end
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      do_reset();

      // impulse response through b0 only
      cfg_write(ADDR_B0, 16'sh4000);
      cfg_write(ADDR_A1, 16'sh0000);
      cfg_write(ADDR_A2, 16'sh0000);
      mb0 = 16384; ma1 = 0; ma2 = 0;
      do_sample(100, 0, 0, 1, got);  check("imp0", got, 100);
      do_sample(0, 0, 0, 1, got);    check("imp1", got, 0);
      do_sample(0, 0, 0, 1, got);    check("imp2", got, -100);
      do_sample(0, 0, 0, 1, got);    check("imp3", got, 0);

      // recursion with reset coefficients
      do_reset();
      do_sample(16384, 0, 0, 1, got); check("rec0", got, 16);
      do_sample(0, 0, 0, 1, got);     check("rec1", got, 29);
      for (int i = 0; i < 5; i++) do_sample(0, 0, 0, 1, got);

      // saturation at both rails
      do_reset();
      cfg_write(ADDR_B0, 16'sh7FFF);
      cfg_write(ADDR_A1, 16'sh0000);
      cfg_write(ADDR_A2, 16'sh0000);
      mb0 = 32767; ma1 = 0; ma2 = 0;
      do_sample(32767, 0, 0, 1, got);  check("sat_hi", got, 32767);
      do_sample(-32768, 0, 0, 1, got); check("sat_lo", got, -32768);

      // backpressure and overrun
      do_reset();
      cfg_write(ADDR_B0, 16'sh4000);
      cfg_write(ADDR_A1, 16'sh0000);
      cfg_write(ADDR_A2, 16'sh0000);
      mb0 = 16384; ma1 = 0; ma2 = 0;
      bus.q_ready = 1'b0;
      do_sample(50, 0, 0, 0, got);
      check("ovr_clear_first", bus.overrun, 0);
      do_sample(70, 0, 0, 0, got);
      check("ovr_set", bus.overrun, 1);
      check("ovr_q_second", got, 70);
      bus.clr_overrun = 1'b1;
      @(negedge clk);
      bus.clr_overrun = 1'b0;
      check("ovr_cleared", bus.overrun, 0);
      do_sample(0, 4, 2, 0, got);
      check("ovr_set_wins", bus.overrun, 1);
      bus.q_ready = 1'b1;
      @(negedge clk);
      check("q_valid_drop", bus.q_valid, 0);
      check("q_held", bus.q, -50);

      // coefficient writes racing a sample in flight; addr 3 ignored
      do_reset();
      cfg_write(ADDR_B0, 16'sh4000);
      cfg_write(ADDR_A1, 16'sh2000);
      cfg_write(ADDR_A2, 16'sh0000);
      cfg_write(2'd3, 16'sh1234);
      mb0 = 16384; ma1 = 8192; ma2 = 0;
      do_sample(1000, 0, 0, 1, got); check("race0", got, 1000);
      cfg_a = ADDR_A1; cfg_v = 16'sh0000;
      do_sample(0, 2, 1, 1, got);    check("race_old_a1", got, 500);
      ma1 = 0;
      cfg_a = ADDR_A2; cfg_v = 16'sh4000;
      do_sample(0, 1, 1, 1, got);    check("race_new_a1", got, -1000);
      ma2 = 16384;
      do_sample(0, 0, 0, 1, got);    check("race_new_a2", got, -500);

      // reset in MAC1 aborts the sample and clears history
      do_reset();
      do_sample(16384, 0, 0, 1, got);
      do_sample(0, 0, 0, 1, got);
      do_sample(5000, 3, 3, 0, got);
      #1;
      check("abort_q", bus.q, 0);
      check("abort_q_valid", bus.q_valid, 0);
      check("abort_busy", bus.busy, 0);
      do_reset();
      do_sample(16384, 0, 0, 1, got); check("fresh0", got, 16);
      do_sample(0, 0, 0, 1, got);     check("fresh1", got, 29);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/resonator_mac_sequencer.md
Name: resonator_mac_sequencer

Overview:
- Sample-rate scheduler and controller for a second-order recursive resonator (IIR): y[n] = b0*(x[n]-x[n-2]) + a1*y[n-1] - a2*y[n-2].
- Generates the sample tick internally and sequences one shared 16x17 multiplier and accumulator over three MAC steps per sample.
- Holds run-time-writable coefficient registers and presents each result on a valid/ready output.
- Sits between the ADC-side sample source and downstream audio consumers, replacing the three-multiplier resonator datapath.

Parameters:
- CLOCK_TICKS, 100000: clocks per sample period; tick asserts when the counter equals CLOCK_TICKS-1.
- B0_RST, 16'sh0010: reset value of b0, Q2.14.
- A1_RST, 16'sh74B8: reset value of a1, Q2.14.
- A2_RST, 16'sh3EBA: reset value of a2, Q2.14.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- d  in  16  signed input sample, captured on tick.
- cfg_we  in  1  coefficient write strobe.
- cfg_addr  in  2  coefficient select: 0=b0, 1=a1, 2=a2; 3 is ignored.
- cfg_wdata  in  16  signed coefficient value, Q2.14.
- q  out  16  signed filter output.
- q_valid  out  1  q holds a new, unconsumed result.
- q_ready  in  1  downstream accepts q.
- enable  out  1  one-cycle sample tick.
- busy  out  1  FSM is not in IDLE.
- overrun  out  1  sticky error flag.
- clr_overrun  in  1  clears overrun.

Behaviour:
- Reset (async assert, sync release):
  - outputs: q=0, q_valid=0, enable=0, busy=0, overrun=0.
  - state: tick counter=0, x1=x2=y1=y2=0, coefficients = *_RST, FSM=IDLE.
- Tick: the counter wraps modulo CLOCK_TICKS. enable=1 for exactly one clock when counter==CLOCK_TICKS-1.
- FSM states: IDLE, LOAD, MAC0, MAC1, MAC2, OUT.
  - IDLE -> LOAD on enable. On entry to LOAD:
    - latch d into x0;
    - snapshot the three coefficients into shadow registers;
    - form diff = x0 - x2 at 17 bits, sign-extended, no wrap.
  - LOAD -> MAC0: acc = b0*diff.
  - MAC0 -> MAC1: acc += a1*y1.
  - MAC1 -> MAC2: acc -= a2*y2.
  - MAC2 -> OUT:
    - y = sat16(acc >>> 14), arithmetic shift, truncation toward -inf;
    - q<=y, q_valid<=1;
    - shift histories: x2<=x1, x1<=x0, y2<=y1, y1<=y.
  - OUT -> IDLE unconditionally, one cycle. busy=1 in every state except IDLE.
- Latency: enable high in cycle T -> q_valid rises in cycle T+5. Histories update once per sample, independent of the output handshake.
- Width rules:
  - products are 33-bit signed;
  - accumulator is 36-bit signed;
  - saturation clamps to [-32768, 32767].
- Multiplier operand mux selects (b0,diff), (a1,y1), (a2,y2) by state. Only one multiply is issued per cycle.
- Output handshake:
  - q_valid drops on the cycle after q_valid&&q_ready;
  - q is stable while q_valid=1 and is held after acceptance.
- Overrun, set on either condition; the new event still proceeds:
  - a new result is written in OUT while q_valid=1 and q_ready=0: q is overwritten, q_valid stays 1;
  - enable arrives while busy=1 (only possible if CLOCK_TICKS<6): that tick is dropped.
- overrun clears only on clr_overrun. If a set and a clear coincide, set wins.
- Coefficient writes take effect at the next LOAD. A write during MAC0-MAC2 does not disturb the sample in flight. cfg_addr=3 writes are discarded.
- Reset asserted mid-sample aborts immediately; no partial result appears on q.

Decomposition:
- Shared package resonator_pkg:
  - typedef state_t (the six states);
  - typedef coef_t (logic signed [15:0]);
  - localparams COEF_FRAC=14, ACC_W=36;
  - cfg address constants ADDR_B0/ADDR_A1/ADDR_A2.
- One natural sub-module, resonator_mac: registered multiply-accumulate with clear/add/subtract control and a saturating Q2.14 output stage. The FSM, tick counter, history and coefficient registers stay in the top.

Test Plan:
- Impulse, b0=0x4000, a1=a2=0, d=100 on tick 1 then 0, q_ready=1 -> q sequence 100, 0, -100, 0; q_valid exactly 5 cycles after each enable.
- Resonator recursion, default coefficients, d=16384 one sample then 0 -> q[0]=16, q[1]=29; samples 2-6 match a bit-exact golden model with no mismatch.
- Saturation, b0=0x7FFF, a1=a2=0, x2=0, d=32767 -> q=32767; d=-32768 -> q=-32768.
- Backpressure, q_ready=0 across two ticks -> overrun=1, q = second result; clr_overrun pulse -> overrun=0; clr_overrun asserted in the same cycle as a new overrun -> overrun stays 1.
- Config race, write a1=0 during MAC0 of sample n -> sample n uses the old a1, sample n+1 uses a1=0.
- Reset pulse during MAC1 -> q=0, q_valid=0, histories zero; after release, first result equals the result of a fresh start.
